// File: rtl/lift_req_sched.sv
// lift_req_sched: collective lift call scheduler producing the next target floor for a lift controller.
// Define LIFT_SCHED_DWELL_EN for a DWELL_CYCLES-long door dwell; otherwise dwell lasts one clock.
module lift_req_sched #(
  parameter int NUM_FLOORS   = 8,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [5:0]            cur_floor,
  input  logic                  at_stop,
  output logic [5:0]            req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DWELL} state_t;
  if (NUM_FLOORS < 2 || NUM_FLOORS > 32) begin : g_bad_floors
    $error("NUM_FLOORS out of range");
  end
  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
    $error("DWELL_CYCLES out of range");
  end
  state_t                state, nstate;
  logic                  last_up, nlast_up;
  logic [5:0]            nreq, up_tgt, dn_tgt;
  logic [NUM_FLOORS-1:0] cur_mask, clr;
  logic                  above, below, here, in_rng, arrive, ex_up, ex_dn, dwell_hold;
  always_comb begin
    cur_mask = '0;
    up_tgt = cur_floor;
    dn_tgt = cur_floor;
    above = 1'b0;
    below = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      cur_mask[i] = 6'(i) == cur_floor;
      if (pending[i] && 6'(i) > cur_floor) begin
        up_tgt = 6'(i);
        above = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && 6'(i) < cur_floor) begin
        dn_tgt = 6'(i);
        below = 1'b1;
      end
  end
  assign in_rng = cur_floor < 6'(NUM_FLOORS);
  assign here   = |(pending & cur_mask);
  assign arrive = (state == MOVE_UP || state == MOVE_DOWN) && cur_floor == req_floor && at_stop;
  assign ex_up  = above && (last_up || !below);
  assign ex_dn  = below && !ex_up;
`ifdef LIFT_SCHED_DWELL_EN
  logic [7:0] dwell_cnt;
  logic       hit, load;
  assign hit        = |((pending | call_btn) & cur_mask);
  assign dwell_hold = hit || dwell_cnt > 8'd1;
  assign load       = in_rng && nstate == DWELL && (state != DWELL || hit);
  always_ff @(posedge clk)
    if (reset) dwell_cnt <= '0;
    else if (in_rng) dwell_cnt <= load ? 8'(DWELL_CYCLES) : dwell_cnt - {7'd0, dwell_cnt != 8'd0};
`else
  assign dwell_hold = 1'b0;
`endif
  // Out-of-range floor freezes the FSM; only pending keeps accumulating.
  always_comb begin
    nstate = state;
    nlast_up = last_up;
    nreq = req_floor;
    clr = '0;
    if (in_rng) begin
      if (state == IDLE) begin
        nreq = cur_floor;
        if (here) begin
          nstate = DWELL;
          clr = cur_mask;
        end else if (above) begin
          nstate = MOVE_UP;
          nlast_up = 1'b1;
          nreq = up_tgt;
        end else if (below) begin
          nstate = MOVE_DOWN;
          nlast_up = 1'b0;
          nreq = dn_tgt;
        end
      end else if (arrive) begin
        nstate = DWELL;
        clr = cur_mask;
      end else if (state == MOVE_UP && above) nreq = up_tgt;
      else if (state == MOVE_DOWN && below) nreq = dn_tgt;
      else if (state == DWELL || !here) begin
        if (state == DWELL) begin
          nreq = cur_floor;
          clr = cur_mask;
        end
        if (state != DWELL || !dwell_hold) begin
          if (ex_up) begin
            nstate = MOVE_UP;
            nlast_up = 1'b1;
            nreq = up_tgt;
          end else if (ex_dn) begin
            nstate = MOVE_DOWN;
            nlast_up = 1'b0;
            nreq = dn_tgt;
          end else nstate = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      last_up <= 1'b1;
      pending <= '0;
      req_floor <= '0;
      dir_up <= 1'b0;
      dir_down <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nstate;
      last_up <= nlast_up;
      pending <= (pending | call_btn) & ~clr;
      req_floor <= nreq;
      dir_up <= nstate == MOVE_UP;
      dir_down <= nstate == MOVE_DOWN;
      busy <= nstate != IDLE;
    end
endmodule
